fifo_req_gen: RTL
=================

// Module: fifo_req_gen
// PURPOSE
//  Upstream stage of the 4-bit FIFO: turns raw read/write push-buttons and din switches into clean FIFO requests.
//  Synchronises and debounces each button and emits one single-cycle wr_en/rd_en per press.
//  Requests are gated against full/empty, and rejected requests are counted.
//  Sits between board I/O and the FIFO, in the FIFO's own clock domain.
// PARAMETERS
//  DEB_CYCLES     50000  consecutive stable synchronised samples needed to accept a press or a release (>=2)
//  REPEAT_CYCLES  500000 hold period between auto-repeat pulses (used only with FIFO_REQ_AUTOREPEAT_EN)
//  DW             4      data width of din / din_q
// PORTS
//  clk_in       in   1   single clock; FIFO clock domain
//  reset        in   1   asynchronous, active-low reset (0 = in reset)
//  write        in   1   raw write button, asynchronous
//  read         in   1   raw read button, asynchronous
//  din          in   DW  raw data switches, asynchronous
//  full         in   1   FIFO full flag, synchronous to clk_in
//  empty        in   1   FIFO empty flag, synchronous to clk_in
//  wr_en        out  1   one-cycle write request to the FIFO
//  rd_en        out  1   one-cycle read request to the FIFO
//  din_q        out  DW  data for the FIFO; valid in the cycle wr_en is high, held otherwise
//  wr_drop_cnt  out  8   writes rejected because full was set; saturates at 255
//  rd_drop_cnt  out  8   reads rejected because empty was set; saturates at 255
// BEHAVIOUR
//  Reset (async assert, sync deassert via the 2-flop chain):
//   - all outputs go to 0; every FSM enters IDLE; synchronisers and counters clear.
//  Synchronisation: write, read and din each pass through 2 flops before any use.
//  Per-button FSM (one instance each):
//   - IDLE: stays while the synced input is 0; on 1, clear the counter and go to DEB_ON.
//   - DEB_ON: counts while the input is 1; a 0 returns to IDLE.
//     When the count reaches DEB_CYCLES-1, raise the press strobe for 1 cycle and go to HELD.
//   - HELD: stays while the input is 1; on 0, clear the counter and go to DEB_OFF.
//   - DEB_OFF: counts while the input is 0; a 1 returns to HELD.
//     When the count reaches DEB_CYCLES-1, go to IDLE.
//  Latency: a raw edge held stable produces wr_en/rd_en on the (DEB_CYCLES+3)th clk_in edge after it is first sampled.
//  Glitches shorter than DEB_CYCLES produce no strobe. Exactly one strobe is produced per accepted press.
//  Gating (registered outputs; uses full/empty as sampled in the strobe cycle):
//   - write strobe and full=0: wr_en=1 for 1 cycle, and din_q loads the synced din in that same cycle.
//   - write strobe and full=1: no wr_en; wr_drop_cnt += 1, saturating.
//   - read strobe and empty=0: rd_en=1 for 1 cycle.
//   - read strobe and empty=1: no rd_en; rd_drop_cnt += 1, saturating.
//   - simultaneous write and read strobes are evaluated independently; both may issue in the same cycle.
//  Reset mid-debounce or mid-hold: any pending strobe is discarded; no pulse is emitted after release of reset.
// CONFIGURATION
//  FIFO_REQ_AUTOREPEAT_EN defined:
//   - in HELD, a repeat counter runs; every REPEAT_CYCLES cycles it fires another strobe, gated as above.
//   - the counter clears on leaving HELD.
//  Not defined: exactly one strobe per press; the repeat counter is not instantiated.
// STRUCTURE
//  Package fifo_req_pkg:
//   - FSM state encodings IDLE/DEB_ON/HELD/DEB_OFF (2 bits);
//   - counter width function clog2 and DROP_CNT_W=8.
//  Sub-module btn_debounce (sync + FSM + counter + optional repeat; one strobe output).
//   - Two instances: write and read. The din synchroniser, gating and drop counters live in the top.
// TESTING  (bench DEB_CYCLES=4, REPEAT_CYCLES=16)
//  1. Assert reset=0 mid-press, release -> all outputs 0, no wr_en for the following 40 cycles.
//  2. din=4'hA, write high 10 cycles, full=0 -> exactly one wr_en on edge 7 after first sample; din_q=4'hA.
//  3. write glitch high 3 cycles -> no wr_en; bounce 1-0-1 during release -> still one wr_en total.
//  4. full=1, 3 write presses -> no wr_en, wr_drop_cnt=3; empty=1, 300 read presses -> rd_drop_cnt=255.
//  5. read and write pressed together, full=0, empty=0 -> rd_en and wr_en both high in the same cycle.
//  6. FIFO_REQ_AUTOREPEAT_EN, write held 60 cycles -> 1+3 wr_en pulses spaced 16 cycles; without the macro -> 1.

Source files
------------

// File: rtl/fifo_req_pkg.sv
// rtl/fifo_req_pkg.sv - shared state encodings, counter sizing helper and drop counter width for fifo_req_gen
package fifo_req_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEB_ON  = 2'd1,
        HELD    = 2'd2,
        DEB_OFF = 2'd3
    } btn_state_t;

    localparam int DROP_CNT_W = 8;

    // Width needed to hold 0..v-1; never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_req_gen_btn_debounce.sv
// rtl/fifo_req_gen_btn_debounce.sv - button synchroniser + debounce FSM emitting one strobe per press (FIFO_REQ_AUTOREPEAT_EN adds repeats)
module btn_debounce
    import fifo_req_pkg::*;
#(
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_CYCLES = 500000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn,
    output logic strobe
);

    localparam int                CNT_W    = clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync;
    logic             btn_s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    assign btn_s = sync[1];

`ifdef FIFO_REQ_AUTOREPEAT_EN
    localparam int                REP_W    = clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            state  <= IDLE;
            cnt    <= '0;
            strobe <= 1'b0;
`ifdef FIFO_REQ_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            sync   <= {sync[0], btn};
            strobe <= 1'b0;
`ifdef FIFO_REQ_AUTOREPEAT_EN
            if (state != HELD) begin
                rep_cnt <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        cnt   <= '0;
                        state <= DEB_ON;
                    end
                end
                DEB_ON: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt + CNT_W'(1) == CNT_LAST) begin
                        strobe <= 1'b1;
                        state  <= HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        cnt   <= '0;
                        state <= DEB_OFF;
                    end
`ifdef FIFO_REQ_AUTOREPEAT_EN
                    else if (rep_cnt == REP_LAST) begin
                        strobe  <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
`endif
                end
                DEB_OFF: begin
                    if (btn_s) begin
                        state <= HELD;
                    end else if (cnt + CNT_W'(1) == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fifo_req_gen.sv
// rtl/fifo_req_gen.sv - debounced, full/empty-gated FIFO write/read request generator (optional FIFO_REQ_AUTOREPEAT_EN)
module fifo_req_gen
    import fifo_req_pkg::*;
#(
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_CYCLES = 500000,
    parameter int DW            = 4
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  write,
    input  logic                  read,
    input  logic [DW-1:0]         din,
    input  logic                  full,
    input  logic                  empty,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [DW-1:0]         din_q,
    output logic [DROP_CNT_W-1:0] wr_drop_cnt,
    output logic [DROP_CNT_W-1:0] rd_drop_cnt
);

    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    logic          rst_meta;
    logic          rst_n;
    logic [DW-1:0] din_m;
    logic [DW-1:0] din_s;
    logic          wr_strb;
    logic          rd_strb;

    // Reset asserts immediately but releases only after two clean clk_in edges.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_wr_deb (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .btn    (write),
        .strobe (wr_strb)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rd_deb (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .btn    (read),
        .strobe (rd_strb)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            din_m       <= '0;
            din_s       <= '0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            din_q       <= '0;
            wr_drop_cnt <= '0;
            rd_drop_cnt <= '0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            if (wr_strb) begin
                if (!full) begin
                    wr_en <= 1'b1;
                    din_q <= din_s;
                end else if (wr_drop_cnt != DROP_MAX) begin
                    wr_drop_cnt <= wr_drop_cnt + DROP_CNT_W'(1);
                end
            end
            if (rd_strb) begin
                if (!empty) begin
                    rd_en <= 1'b1;
                end else if (rd_drop_cnt != DROP_MAX) begin
                    rd_drop_cnt <= rd_drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

endmodule
